// File: rtl/btn_press_conditioner.sv
// btn_press_conditioner: front-end for the three raw game buttons.
//   Each button is synchronised (2 flops) and debounced in its own lane.
//   A single small FSM turns the first accepted rise into a one-cycle
//   press_valid pulse with press_code (0/1/2 = button, 3 = multi-press).
//   After a commit, no new press is accepted until every button is released.
// Build option: BTN_ACTIVE_LOW_EN -- pins are active-low and are inverted
//   before the synchroniser; all internal logic stays active-high.

module btn_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             ff1, ff2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after it persists DEBOUNCE_CYCLES cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      ff1    <= 1'b0;
      ff2    <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      ff1 <= raw;
      ff2 <= ff1;
      if (ff2 != stable) begin
        if (cnt == LAST) begin
          stable <= ff2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module btn_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] btn,
  input  logic       enable,
  output logic       press_valid,
  output logic [1:0] press_code,
  output logic       press_multi,
  output logic       busy
);
  localparam int NUM_BTN = 3;

  typedef enum logic {IDLE, WAIT_RELEASE} state_t;

  state_t             state, state_nxt;
  logic [NUM_BTN-1:0] btn_in, stable, stable_q, rise;
  logic               commit, multi_nxt;
  logic [1:0]         code_nxt;

`ifdef BTN_ACTIVE_LOW_EN
  assign btn_in = ~btn;
`else
  assign btn_in = btn;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clock (clock),
      .reset (reset),
      .raw   (btn_in[i]),
      .stable(stable[i])
    );
  end

  assign rise = stable & ~stable_q;

  // Next-state and commit decode; a held button can only fire via a fresh rise
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    code_nxt  = press_code;
    multi_nxt = press_multi;
    case (state)
      IDLE: begin
        if (enable && (|rise)) begin
          commit    = 1'b1;
          state_nxt = WAIT_RELEASE;
          multi_nxt = 1'b0;
          case (stable)
            3'b001:  code_nxt = 2'd0;
            3'b010:  code_nxt = 2'd1;
            3'b100:  code_nxt = 2'd2;
            default: begin
              code_nxt  = 2'd3;
              multi_nxt = 1'b1;
            end
          endcase
        end
      end
      WAIT_RELEASE: begin
        if (stable == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered outputs and edge-detect history
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      press_valid <= 1'b0;
      press_code  <= 2'd0;
      press_multi <= 1'b0;
      stable_q    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      press_valid <= commit;
      press_code  <= code_nxt;
      press_multi <= multi_nxt;
      stable_q    <= stable;
      busy        <= |stable;
    end
  end
endmodule

// File: tb/tb_btn_press_conditioner.sv
// Bench for btn_press_conditioner: directed scenarios plus random button
// activity, compared every cycle against a behavioural model. The model
// treats debouncing as "the last DEBOUNCE_CYCLES synchronised samples all
// disagree with the stable level" rather than tracking a counter.
// Build with BTN_ACTIVE_LOW_EN to drive inverted pin levels.

module tb_btn_press_conditioner;
  localparam int D = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] btn;
  logic       enable;
  logic       press_valid;
  logic [1:0] press_code;
  logic       press_multi;
  logic       busy;

  btn_press_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clock      (clock),
    .reset      (reset),
    .btn        (btn),
    .enable     (enable),
    .press_valid(press_valid),
    .press_code (press_code),
    .press_multi(press_multi),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  int cyc_n = 0, npulse = 0, last_pulse = 0;

  // model state
  logic [2:0] m_p1, m_p2, m_stable, m_stable_q;
  logic [2:0] win[$];
  logic       m_wait, m_valid, m_multi, m_busy;
  logic [1:0] m_code;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_stable = '0; m_stable_q = '0;
    win.delete();
    for (int k = 0; k < D; k++) win.push_back(3'b000);
    m_wait = 1'b0; m_valid = 1'b0; m_code = 2'd0; m_multi = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] b, input logic en);
    logic [2:0] obs, nst, rise;
    int         idx;
    obs  = m_p2;             // level the synchroniser presents this cycle
    m_p2 = m_p1;
    m_p1 = b;
    win.push_back(obs);
    if (win.size() > D) void'(win.pop_front());
    nst = m_stable;
    for (int i = 0; i < 3; i++) begin
      bit all_diff = 1'b1;
      foreach (win[k]) if (win[k][i] == m_stable[i]) all_diff = 1'b0;
      if (all_diff) nst[i] = ~m_stable[i];
    end
    rise    = m_stable & ~m_stable_q;
    m_valid = 1'b0;
    if (!m_wait) begin
      if (en && rise != 3'b000) begin
        m_valid = 1'b1;
        m_wait  = 1'b1;
        if ($countones(m_stable) == 1) begin
          idx = 0;
          for (int i = 0; i < 3; i++) if (m_stable[i]) idx = i;
          m_code  = 2'(idx);
          m_multi = 1'b0;
        end else begin
          m_code  = 2'd3;
          m_multi = 1'b1;
        end
      end
    end else if (m_stable == 3'b000) begin
      m_wait = 1'b0;
    end
    m_busy     = |m_stable;
    m_stable_q = m_stable;
    m_stable   = nst;
  endtask

  // one clock: drive logical levels, advance model, check outputs after the edge
  task automatic cyc(input logic [2:0] b, input logic en, input logic rst);
`ifdef BTN_ACTIVE_LOW_EN
    btn = ~b;
`else
    btn = b;
`endif
    enable = en;
    reset  = rst;
    @(posedge clock);
    cyc_n++;
    if (rst) model_reset();
    else model_edge(b, en);
    #1;
    chk("press_valid", 32'(press_valid), 32'(m_valid));
    chk("press_code",  32'(press_code),  32'(m_code));
    chk("press_multi", 32'(press_multi), 32'(m_multi));
    chk("busy",        32'(busy),        32'(m_busy));
    if (press_valid === 1'b1) begin
      npulse++;
      last_pulse = cyc_n;
    end
  endtask

  task automatic hold(input logic [2:0] b, input logic en, input int n);
    for (int k = 0; k < n; k++) cyc(b, en, 1'b0);
  endtask

  int p0;

  initial begin
    model_reset();
    cyc(3'b000, 1'b0, 1'b1);
    cyc(3'b000, 1'b0, 1'b1);
    hold(3'b000, 1'b1, 8);

    // single press: pulse 6 edges after the first sampling edge
    npulse = 0;
    p0 = cyc_n + 1;
    hold(3'b010, 1'b1, 20);
    hold(3'b000, 1'b1, 10);
    chk("t1_pulses", 32'(npulse), 32'd1);
    chk("t1_latency", 32'(last_pulse - p0), 32'(D + 2));
    chk("t1_code", 32'(press_code), 32'd1);

    // short glitches never accepted
    npulse = 0;
    hold(3'b001, 1'b1, 1); hold(3'b000, 1'b1, 1);
    hold(3'b001, 1'b1, 1); hold(3'b000, 1'b1, 1);
    hold(3'b001, 1'b1, 2); hold(3'b000, 1'b1, 10);
    chk("t2_pulses", 32'(npulse), 32'd0);
    chk("t2_busy", 32'(busy), 32'd0);

    // simultaneous rises
    npulse = 0;
    hold(3'b101, 1'b1, 12);
    hold(3'b000, 1'b1, 10);
    chk("t3_pulses", 32'(npulse), 32'd1);
    chk("t3_code", 32'(press_code), 32'd3);
    chk("t3_multi", 32'(press_multi), 32'd1);

    // second button while first held is ignored
    npulse = 0;
    hold(3'b100, 1'b1, 10);
    hold(3'b101, 1'b1, 10);
    hold(3'b000, 1'b1, 10);
    chk("t4_pulses", 32'(npulse), 32'd1);
    chk("t4_code", 32'(press_code), 32'd2);
    hold(3'b001, 1'b1, 10);
    hold(3'b000, 1'b1, 10);
    chk("t4_repress", 32'(npulse), 32'd2);
    chk("t4_code0", 32'(press_code), 32'd0);

    // held through enable rising does not fire
    npulse = 0;
    hold(3'b010, 1'b0, 10);
    hold(3'b010, 1'b1, 10);
    hold(3'b000, 1'b1, 10);
    chk("t5_nofire", 32'(npulse), 32'd0);
    hold(3'b010, 1'b1, 10);
    hold(3'b000, 1'b1, 10);
    chk("t5_repress", 32'(npulse), 32'd1);
    chk("t5_code", 32'(press_code), 32'd1);

    // reset while waiting for release re-debounces the held button
    npulse = 0;
    hold(3'b001, 1'b1, 10);
    cyc(3'b001, 1'b1, 1'b1);
    chk("t6_rst_valid", 32'(press_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    p0 = cyc_n + 1;
    hold(3'b001, 1'b1, 12);
    chk("t6_pulses", 32'(npulse), 32'd2);
    chk("t6_latency", 32'(last_pulse - p0), 32'(D + 2));
    chk("t6_code", 32'(press_code), 32'd0);
    hold(3'b000, 1'b1, 10);

    // random activity
    for (int s = 0; s < 400; s++) begin
      logic [2:0] b;
      logic       en;
      int         n;
      case ($urandom_range(0, 5))
        0, 1:    b = 3'b000;
        2:       b = 3'b001;
        3:       b = 3'b010;
        4:       b = 3'b100;
        default: b = 3'($urandom_range(0, 7));
      endcase
      en = ($urandom_range(0, 7) != 0);
      n  = $urandom_range(1, 12);
      if ($urandom_range(0, 60) == 0) cyc(b, en, 1'b1);
      hold(b, en, n);
    end
    hold(3'b000, 1'b1, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
